// File: rtl/iterative_shifter_pkg.sv
// Shared command codes and state encoding for the multicycle shift unit.
// The ALU control decoder drives shifter_control with these same constants.
package iterative_shifter_pkg;

    typedef enum logic [2:0] {
        CMD_NOP  = 3'b000,
        CMD_LOAD = 3'b001,
        CMD_SLL  = 3'b010,
        CMD_SRL  = 3'b011,
        CMD_SRA  = 3'b100
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/iterative_shifter_shift_step.sv
// Single-bit shift step over WIDTH bits, selected by the latched op.
// Non-shift ops pass the operand through unchanged.
module shift_step
    import iterative_shifter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  cmd_e             op,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_comb begin
        q = d;
        unique case (op)
            CMD_SLL: q = {d[WIDTH-2:0], 1'b0};
            CMD_SRL: q = {1'b0, d[WIDTH-1:1]};
            CMD_SRA: q = {d[WIDTH-1], d[WIDTH-1:1]};
            default: q = d;
        endcase
    end

endmodule

// File: rtl/iterative_shifter.sv
// Multicycle shifter: LOAD an operand, then shift one bit per clock
// until the captured amount is exhausted; busy/done are registered.
module iterative_shifter
    import iterative_shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       shifter_control,
    input  logic [WIDTH-1:0] data_in,
    input  logic [CNT_W-1:0] shamt,
    output logic [WIDTH-1:0] data_out,
    output logic             busy,
    output logic             done
);

    state_e             state_q, state_d;
    cmd_e               op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [WIDTH-1:0]   step_out;
    logic               busy_q, done_q;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .op (op_q),
        .d  (data_q),
        .q  (step_out)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        unique case (state_q)
            ST_SHIFT: begin
                // Commands are ignored until the count drains.
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    data_d = step_out;
                    cnt_d  = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                unique case (shifter_control)
                    CMD_LOAD: data_d = data_in;
                    CMD_SLL, CMD_SRL, CMD_SRA: begin
                        op_d    = cmd_e'(shifter_control);
                        cnt_d   = shamt;
                        state_d = ST_SHIFT;
                    end
                    default: ;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= CMD_NOP;
            cnt_q   <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            busy_q  <= (state_d == ST_SHIFT);
            done_q  <= (state_d == ST_DONE);
        end
    end

    assign data_out = data_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
